// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the instruction-download debug path: loader states,
// end-of-program marker and program-memory depth derivation.
package mips_dbg_pkg;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RUN       = 3'd2,
        ST_STEP_WAIT = 3'd3,
        ST_HALTED    = 3'd4
    } loader_state_t;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/mips_program_loader_if.sv
// Program-memory write port: the loader drives it, the memory consumes it.
interface mips_program_loader_if #(
    parameter int ADDR_W = 5
);
    logic              PM_WE;
    logic [ADDR_W-1:0] PM_ADDR;
    logic [31:0]       PM_WDATA;

    modport master (output PM_WE, PM_ADDR, PM_WDATA);
    modport slave  (input  PM_WE, PM_ADDR, PM_WDATA);
endinterface

// File: rtl/mips_program_loader_step_edge_detect.sv
// Rising-edge detector for the single-step request; the history register
// makes a STEP held high produce exactly one pulse.
module step_edge_detect (
    input  logic CLK,
    input  logic RESET,
    input  logic STEP,
    output logic step_rise
);
    logic step_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            step_q <= 1'b0;
        end else begin
            step_q <= STEP;
        end
    end

    assign step_rise = STEP & ~step_q;
endmodule

// File: rtl/mips_program_loader.sv
// Download receiver: writes incoming words to program memory from address 0,
// then releases the pipeline and gates its enable (free-run or single-step).
module mips_program_loader #(
    parameter int          ADDR_W    = 5,
    parameter logic [31:0] HALT_WORD = mips_dbg_pkg::HALT_WORD
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [31:0]            INSTRUCTION_IN,
    input  logic                   FLAG_I,
    input  logic                   FLAG_STEP,
    input  logic                   STEP,
    input  logic                   CPU_HALTED,
    mips_program_loader_if.master  pm,
    output logic                   CPU_RESET,
    output logic                   CPU_ENABLE,
    output logic [ADDR_W:0]        WORD_COUNT,
    output logic                   OVERFLOW,
    output logic [2:0]             STATE
);
    import mips_dbg_pkg::*;

    localparam int             DEPTH      = depth_of(ADDR_W);
    localparam logic [ADDR_W:0] FULL_COUNT = DEPTH[ADDR_W:0];

    loader_state_t state;
    loader_state_t exit_state;
    logic          step_rise;
    logic          loading;
    logic          mem_full;
    logic          is_halt;
    logic          accept;
    logic          load_done;

    step_edge_detect u_step_edge (
        .CLK       (CLK),
        .RESET     (RESET),
        .STEP      (STEP),
        .step_rise (step_rise)
    );

    assign loading    = (state == ST_IDLE) || (state == ST_LOAD);
    assign mem_full   = (WORD_COUNT == FULL_COUNT);
    assign is_halt    = (INSTRUCTION_IN == HALT_WORD);
    assign accept     = loading && FLAG_I && !mem_full;
    // A gap in FLAG_I, the halt marker or a word that no longer fits ends the load.
    assign load_done  = loading && ((state == ST_LOAD && !FLAG_I) ||
                                    (FLAG_I && (mem_full || is_halt)));
    assign exit_state = FLAG_STEP ? ST_STEP_WAIT : ST_RUN;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            pm.PM_WE    <= 1'b0;
            pm.PM_ADDR  <= '0;
            pm.PM_WDATA <= '0;
            CPU_RESET   <= 1'b1;
            CPU_ENABLE  <= 1'b0;
            WORD_COUNT  <= '0;
            OVERFLOW    <= 1'b0;
        end else begin
            // NOTE: write enable defaults low each cycle so it is a one-cycle strobe per accepted word.
            pm.PM_WE <= 1'b0;
            case (state)
                ST_IDLE, ST_LOAD: begin
                    CPU_RESET  <= 1'b1;
                    CPU_ENABLE <= 1'b0;
                    if (accept) begin
                        pm.PM_WE    <= 1'b1;
                        pm.PM_ADDR  <= WORD_COUNT[ADDR_W-1:0];
                        pm.PM_WDATA <= INSTRUCTION_IN;
                        WORD_COUNT  <= WORD_COUNT + 1'b1;
                        state       <= ST_LOAD;
                    end
                    if (loading && FLAG_I && mem_full) begin
                        OVERFLOW <= 1'b1;
                    end
                    if (load_done) begin
                        state      <= exit_state;
                        CPU_RESET  <= 1'b0;
                        CPU_ENABLE <= !FLAG_STEP;
                    end
                end
                ST_RUN: begin
                    CPU_RESET <= 1'b0;
                    if (CPU_HALTED) begin
                        state      <= ST_HALTED;
                        CPU_ENABLE <= 1'b0;
                    end else if (FLAG_STEP) begin
                        state      <= ST_STEP_WAIT;
                        CPU_ENABLE <= 1'b0;
                    end else begin
                        CPU_ENABLE <= 1'b1;
                    end
                end
                ST_STEP_WAIT: begin
                    CPU_RESET <= 1'b0;
                    // Halt takes priority over a step edge arriving in the same cycle.
                    if (CPU_HALTED) begin
                        state      <= ST_HALTED;
                        CPU_ENABLE <= 1'b0;
                    end else if (!FLAG_STEP) begin
                        state      <= ST_RUN;
                        CPU_ENABLE <= 1'b1;
                    end else begin
                        CPU_ENABLE <= step_rise;
                    end
                end
                ST_HALTED: begin
                    CPU_RESET  <= 1'b0;
                    CPU_ENABLE <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    CPU_RESET  <= 1'b1;
                    CPU_ENABLE <= 1'b0;
                end
            endcase
        end
    end

    assign STATE = state;
endmodule

// File: tb/tb_mips_program_loader.sv
// Scoreboard bench for mips_program_loader: a 32-word instance for the main
// scenarios and a 4-word instance for the overflow case.
module tb_mips_program_loader;
    localparam int AW  = 5;
    localparam int AW2 = 2;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RESET, FLAG_I, FLAG_STEP, STEP, CPU_HALTED;
    logic [31:0] INSTRUCTION_IN;
    logic        CPU_RESET, CPU_ENABLE, OVERFLOW;
    logic [AW:0] WORD_COUNT;
    logic [2:0]  STATE;

    logic         RESET2, FLAG_I2;
    logic [31:0]  INSTRUCTION_IN2;
    logic         CPU_RESET2, CPU_ENABLE2, OVERFLOW2;
    logic [AW2:0] WORD_COUNT2;
    logic [2:0]   STATE2;

    mips_program_loader_if #(.ADDR_W(AW))  pm  ();
    mips_program_loader_if #(.ADDR_W(AW2)) pm2 ();

    mips_program_loader #(.ADDR_W(AW)) dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION_IN(INSTRUCTION_IN), .FLAG_I(FLAG_I),
        .FLAG_STEP(FLAG_STEP), .STEP(STEP), .CPU_HALTED(CPU_HALTED), .pm(pm),
        .CPU_RESET(CPU_RESET), .CPU_ENABLE(CPU_ENABLE), .WORD_COUNT(WORD_COUNT),
        .OVERFLOW(OVERFLOW), .STATE(STATE)
    );

    mips_program_loader #(.ADDR_W(AW2)) dut2 (
        .CLK(CLK), .RESET(RESET2), .INSTRUCTION_IN(INSTRUCTION_IN2), .FLAG_I(FLAG_I2),
        .FLAG_STEP(FLAG_STEP), .STEP(STEP), .CPU_HALTED(CPU_HALTED), .pm(pm2),
        .CPU_RESET(CPU_RESET2), .CPU_ENABLE(CPU_ENABLE2), .WORD_COUNT(WORD_COUNT2),
        .OVERFLOW(OVERFLOW2), .STATE(STATE2)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t q1[$];
    wr_t q2[$];
    int  total = 0;
    int  bad   = 0;

    logic [31:0] prog [4] = '{32'h2001_0005, 32'h2002_0003, 32'h0022_1820, 32'hFFFF_FFFF};

    // One clock; outputs are examined 1 time unit after the edge and any
    // memory write is matched against the head of its scoreboard queue.
    task automatic advance();
        wr_t e;
        @(posedge CLK);
        #1;
        if (pm.PM_WE === 1'b1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL sb1_unexpected_write addr=%0d data=%h expected=no_write", pm.PM_ADDR, pm.PM_WDATA);
            end else begin
                e = q1.pop_front();
                if ({3'b000, pm.PM_ADDR} !== e.addr || pm.PM_WDATA !== e.data) begin
                    bad++;
                    $display("FAIL sb1_write got=%0d:%h expected=%0d:%h", pm.PM_ADDR, pm.PM_WDATA, e.addr, e.data);
                end
            end
        end
        if (pm2.PM_WE === 1'b1) begin
            total++;
            if (q2.size() == 0) begin
                bad++;
                $display("FAIL sb2_unexpected_write addr=%0d data=%h expected=no_write", pm2.PM_ADDR, pm2.PM_WDATA);
            end else begin
                e = q2.pop_front();
                if ({6'b000000, pm2.PM_ADDR} !== e.addr || pm2.PM_WDATA !== e.data) begin
                    bad++;
                    $display("FAIL sb2_write got=%0d:%h expected=%0d:%h", pm2.PM_ADDR, pm2.PM_WDATA, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1; FLAG_I = 1'b0; STEP = 1'b0; CPU_HALTED = 1'b0; FLAG_STEP = 1'b0;
        INSTRUCTION_IN = '0;
        advance();
        advance();
        RESET = 1'b0;
    endtask

    task automatic push1(input int addr, input logic [31:0] data);
        wr_t e;
        e.addr = 8'(addr);
        e.data = data;
        q1.push_back(e);
    endtask

    task automatic test_reset();
        RESET = 1'b1; FLAG_I = 1'b1; INSTRUCTION_IN = 32'h1234_5678;
        FLAG_STEP = 1'b0; STEP = 1'b0; CPU_HALTED = 1'b0;
        for (int i = 0; i < 3; i++) begin
            advance();
            total++;
            if (pm.PM_WE !== 1'b0 || CPU_RESET !== 1'b1 || STATE !== 3'd0 || WORD_COUNT !== '0 ||
                CPU_ENABLE !== 1'b0 || OVERFLOW !== 1'b0 || pm.PM_ADDR !== '0 || pm.PM_WDATA !== '0) begin
                bad++;
                $display("FAIL reset cyc=%0d we=%b rst=%b st=%0d cnt=%0d en=%b ov=%b expected we=0 rst=1 st=0 cnt=0 en=0 ov=0",
                         i, pm.PM_WE, CPU_RESET, STATE, WORD_COUNT, CPU_ENABLE, OVERFLOW);
            end
        end
        RESET = 1'b0; FLAG_I = 1'b0;
        advance();
        total++;
        if (STATE !== 3'd0 || CPU_RESET !== 1'b1) begin
            bad++;
            $display("FAIL idle_after_reset st=%0d rst=%b expected st=0 rst=1", STATE, CPU_RESET);
        end
    endtask

    task automatic load_program(input logic step_mode);
        FLAG_STEP = step_mode;
        for (int i = 0; i < 4; i++) begin
            FLAG_I = 1'b1; INSTRUCTION_IN = prog[i];
            push1(i, prog[i]);
            advance();
            total++;
            if (WORD_COUNT !== 6'(i + 1)) begin
                bad++;
                $display("FAIL load_count word=%0d got=%0d expected=%0d", i, WORD_COUNT, i + 1);
            end
            if (i < 3) begin
                total++;
                if (STATE !== 3'd1 || CPU_RESET !== 1'b1) begin
                    bad++;
                    $display("FAIL load_state word=%0d st=%0d rst=%b expected st=1 rst=1", i, STATE, CPU_RESET);
                end
            end
        end
        FLAG_I = 1'b0;
    endtask

    task automatic test_normal_load();
        do_reset();
        load_program(1'b0);
        total++;
        if (STATE !== 3'd2 || CPU_RESET !== 1'b0 || CPU_ENABLE !== 1'b1) begin
            bad++;
            $display("FAIL first_run st=%0d rst=%b en=%b expected st=2 rst=0 en=1", STATE, CPU_RESET, CPU_ENABLE);
        end
        advance();
        total++;
        if (pm.PM_WE !== 1'b0 || CPU_ENABLE !== 1'b1 || q1.size() != 0) begin
            bad++;
            $display("FAIL run_steady we=%b en=%b pending=%0d expected we=0 en=1 pending=0", pm.PM_WE, CPU_ENABLE, q1.size());
        end
        CPU_HALTED = 1'b1;
        advance();
        CPU_HALTED = 1'b0;
        total++;
        if (STATE !== 3'd4 || CPU_ENABLE !== 1'b0 || CPU_RESET !== 1'b0) begin
            bad++;
            $display("FAIL halt st=%0d en=%b rst=%b expected st=4 en=0 rst=0", STATE, CPU_ENABLE, CPU_RESET);
        end
        FLAG_I = 1'b1; INSTRUCTION_IN = 32'hDEAD_BEEF;
        advance();
        advance();
        FLAG_I = 1'b0;
        total++;
        if (STATE !== 3'd4 || CPU_ENABLE !== 1'b0 || WORD_COUNT !== 6'd4) begin
            bad++;
            $display("FAIL halted_terminal st=%0d en=%b cnt=%0d expected st=4 en=0 cnt=4", STATE, CPU_ENABLE, WORD_COUNT);
        end
    endtask

    task automatic test_step_mode();
        logic [16:0] seq = 17'b00100011111001000;
        logic        prev = 1'b0;
        logic        exp_en;
        int          pulses = 0;
        do_reset();
        load_program(1'b1);
        total++;
        if (STATE !== 3'd3 || CPU_RESET !== 1'b0 || CPU_ENABLE !== 1'b0) begin
            bad++;
            $display("FAIL step_entry st=%0d rst=%b en=%b expected st=3 rst=0 en=0", STATE, CPU_RESET, CPU_ENABLE);
        end
        for (int i = 0; i < 17; i++) begin
            STEP = seq[16 - i];
            advance();
            exp_en = STEP & ~prev;
            prev   = STEP;
            if (CPU_ENABLE === 1'b1) pulses++;
            total++;
            if (CPU_ENABLE !== exp_en) begin
                bad++;
                $display("FAIL step_enable cyc=%0d got=%b expected=%b", i, CPU_ENABLE, exp_en);
            end
        end
        total++;
        if (pulses != 3) begin
            bad++;
            $display("FAIL step_pulse_count got=%0d expected=3", pulses);
        end
        FLAG_STEP = 1'b0;
        advance();
        total++;
        if (STATE !== 3'd2 || CPU_ENABLE !== 1'b1) begin
            bad++;
            $display("FAIL step_to_run st=%0d en=%b expected st=2 en=1", STATE, CPU_ENABLE);
        end
        FLAG_STEP = 1'b1;
        advance();
        total++;
        if (STATE !== 3'd3 || CPU_ENABLE !== 1'b0) begin
            bad++;
            $display("FAIL run_to_step st=%0d en=%b expected st=3 en=0", STATE, CPU_ENABLE);
        end
        STEP = 1'b1; CPU_HALTED = 1'b1;
        advance();
        STEP = 1'b0; CPU_HALTED = 1'b0;
        total++;
        if (STATE !== 3'd4 || CPU_ENABLE !== 1'b0) begin
            bad++;
            $display("FAIL halt_over_step st=%0d en=%b expected st=4 en=0", STATE, CPU_ENABLE);
        end
        FLAG_STEP = 1'b0;
    endtask

    task automatic test_overflow();
        wr_t e;
        RESET2 = 1'b1; FLAG_I2 = 1'b0; FLAG_STEP = 1'b0;
        advance();
        RESET2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            FLAG_I2 = 1'b1; INSTRUCTION_IN2 = 32'h0000_0100 + 32'(i);
            if (i < 4) begin
                e.addr = 8'(i);
                e.data = INSTRUCTION_IN2;
                q2.push_back(e);
            end
            advance();
            if (i == 3) begin
                total++;
                if (WORD_COUNT2 !== 3'd4 || STATE2 !== 3'd1 || OVERFLOW2 !== 1'b0) begin
                    bad++;
                    $display("FAIL ovf_full cnt=%0d st=%0d ov=%b expected cnt=4 st=1 ov=0", WORD_COUNT2, STATE2, OVERFLOW2);
                end
            end
            if (i == 4) begin
                total++;
                if (OVERFLOW2 !== 1'b1 || STATE2 !== 3'd2 || pm2.PM_WE !== 1'b0) begin
                    bad++;
                    $display("FAIL ovf_drop ov=%b st=%0d we=%b expected ov=1 st=2 we=0", OVERFLOW2, STATE2, pm2.PM_WE);
                end
            end
        end
        FLAG_I2 = 1'b0;
        advance();
        total++;
        if (OVERFLOW2 !== 1'b1 || WORD_COUNT2 !== 3'd4 || STATE2 !== 3'd2 || CPU_ENABLE2 !== 1'b1 ||
            CPU_RESET2 !== 1'b0 || q2.size() != 0) begin
            bad++;
            $display("FAIL ovf_final ov=%b cnt=%0d st=%0d en=%b rst=%b pending=%0d expected ov=1 cnt=4 st=2 en=1 rst=0 pending=0",
                     OVERFLOW2, WORD_COUNT2, STATE2, CPU_ENABLE2, CPU_RESET2, q2.size());
        end
        RESET2 = 1'b1;
    endtask

    task automatic test_flag_drop();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            FLAG_I = 1'b1; INSTRUCTION_IN = prog[i];
            push1(i, prog[i]);
            advance();
        end
        FLAG_I = 1'b0;
        advance();
        total++;
        if (STATE !== 3'd2 || WORD_COUNT !== 6'd2 || pm.PM_WE !== 1'b0 || CPU_ENABLE !== 1'b1 || CPU_RESET !== 1'b0) begin
            bad++;
            $display("FAIL drop_exit st=%0d cnt=%0d we=%b en=%b rst=%b expected st=2 cnt=2 we=0 en=1 rst=0",
                     STATE, WORD_COUNT, pm.PM_WE, CPU_ENABLE, CPU_RESET);
        end
        for (int i = 0; i < 3; i++) begin
            FLAG_I = 1'b1; INSTRUCTION_IN = 32'hCAFE_0000 + 32'(i);
            advance();
            total++;
            if (pm.PM_WE !== 1'b0 || WORD_COUNT !== 6'd2 || STATE !== 3'd2) begin
                bad++;
                $display("FAIL run_ignores_flag_i cyc=%0d we=%b cnt=%0d st=%0d expected we=0 cnt=2 st=2", i, pm.PM_WE, WORD_COUNT, STATE);
            end
        end
        FLAG_I = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            FLAG_I = 1'b1; INSTRUCTION_IN = prog[i];
            push1(i, prog[i]);
            advance();
        end
        RESET = 1'b1; INSTRUCTION_IN = prog[2];
        advance();
        total++;
        if (STATE !== 3'd0 || WORD_COUNT !== '0 || pm.PM_WE !== 1'b0 || CPU_RESET !== 1'b1 || q1.size() != 0) begin
            bad++;
            $display("FAIL mid_load_reset st=%0d cnt=%0d we=%b rst=%b pending=%0d expected st=0 cnt=0 we=0 rst=1 pending=0",
                     STATE, WORD_COUNT, pm.PM_WE, CPU_RESET, q1.size());
        end
        RESET = 1'b0; FLAG_I = 1'b0;
        advance();
        FLAG_I = 1'b1; INSTRUCTION_IN = 32'hAAAA_0000;
        push1(0, 32'hAAAA_0000);
        advance();
        FLAG_I = 1'b0;
        total++;
        if (WORD_COUNT !== 6'd1 || pm.PM_ADDR !== 5'd0 || STATE !== 3'd1) begin
            bad++;
            $display("FAIL reload cnt=%0d addr=%0d st=%0d expected cnt=1 addr=0 st=1", WORD_COUNT, pm.PM_ADDR, STATE);
        end
        advance();
        total++;
        if (STATE !== 3'd2 || q1.size() != 0) begin
            bad++;
            $display("FAIL reload_exit st=%0d pending=%0d expected st=2 pending=0", STATE, q1.size());
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET2 = 1'b1; FLAG_I2 = 1'b0; INSTRUCTION_IN2 = '0;
        test_reset();
        test_normal_load();
        test_step_mode();
        test_overflow();
        test_flag_drop();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_program_loader.md
Name: mips_program_loader

Overview:
- Receive side of the instruction-download interface: accepts 32-bit words on INSTRUCTION_IN qualified by FLAG_I and writes them to consecutive program-memory addresses starting at 0.
- After the download, releases the pipeline and gates its clock-enable, either free-running or single-step according to FLAG_STEP.
- Sits inside TP4, between the top-level download pins and the program memory / pipeline enable.

Parameters:
- ADDR_W, 5, program-memory word-address width; DEPTH = 2**ADDR_W words.
- HALT_WORD, 32'hFFFF_FFFF, end-of-program marker; it is written to memory and also terminates the load.

Ports:
- CLK  in  1  system clock, all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- INSTRUCTION_IN  in  32  instruction word being downloaded.
- FLAG_I  in  1  INSTRUCTION_IN valid this cycle.
- FLAG_STEP  in  1  0 = continuous run, 1 = step mode; level, sampled every cycle.
- STEP  in  1  step request; rising edge = one pipeline cycle.
- CPU_HALTED  in  1  pipeline reports HALT_WORD retired in WB.
- PM_WE  out  1  program-memory write enable.
- PM_ADDR  out  ADDR_W  program-memory word address.
- PM_WDATA  out  32  program-memory write data.
- CPU_RESET  out  1  holds pipeline registers in reset.
- CPU_ENABLE  out  1  pipeline advance enable.
- WORD_COUNT  out  ADDR_W+1  words written so far, 0..DEPTH.
- OVERFLOW  out  1  sticky: a word arrived while memory was full.
- STATE  out  3  encoded FSM state, for debug.

Behaviour:
- Reset values: PM_WE=0, PM_ADDR=0, PM_WDATA=0, CPU_RESET=1, CPU_ENABLE=0, WORD_COUNT=0, OVERFLOW=0, STATE=IDLE. STEP edge detector history cleared to 0.
- States and encodings: IDLE=0, LOAD=1, RUN=2, STEP_WAIT=3, HALTED=4.
- IDLE: CPU_RESET=1. On FLAG_I=1: register the word, go to LOAD.
- LOAD: CPU_RESET=1.
  - Each cycle with FLAG_I=1 and WORD_COUNT<DEPTH: next cycle PM_WE=1, PM_ADDR=WORD_COUNT, PM_WDATA=word; WORD_COUNT increments. Write latency is exactly one cycle.
  - Word equal to HALT_WORD: written, then go to RUN or STEP_WAIT per FLAG_STEP.
  - FLAG_I=0 in LOAD: the load is over; go to RUN or STEP_WAIT. Transfer is back-to-back with no gaps.
  - FLAG_I=1 with WORD_COUNT==DEPTH: word dropped, no write, OVERFLOW<=1, go to RUN or STEP_WAIT.
- Exiting LOAD: PM_WE drops to 0 on the cycle after the last write. CPU_RESET drops to 0 on the first cycle in RUN or STEP_WAIT.
- RUN (FLAG_STEP=0): CPU_ENABLE=1 every cycle. If FLAG_STEP becomes 1: CPU_ENABLE=0 from the next cycle, go to STEP_WAIT.
- STEP_WAIT (FLAG_STEP=1):
  - CPU_ENABLE=0 except exactly one cycle, the cycle after a registered STEP 0->1 edge.
  - A STEP held high gives one pulse only.
  - If FLAG_STEP becomes 0: go to RUN.
- CPU_HALTED=1 in RUN or STEP_WAIT: go to HALTED. CPU_ENABLE=0 from the next cycle. Halt wins over a simultaneous step edge.
- HALTED: terminal. CPU_ENABLE=0, CPU_RESET=0 (register state stays visible). Exit only via RESET.
- FLAG_I in RUN, STEP_WAIT or HALTED: ignored, no memory writes.
- RESET mid-load or mid-run: all outputs return to reset values next cycle. Memory contents are not cleared; they are overwritten on the next load.
- WORD_COUNT saturates at DEPTH. PM_ADDR never wraps.

Decomposition:
- Shared package mips_dbg_pkg:
  - loader state enum/localparams IDLE..HALTED;
  - HALT_WORD constant, also used by the control unit's halt decode;
  - DEPTH derivation.
- One sub-module, step_edge_detect: register STEP, output a one-cycle rising-edge pulse.
- FSM, counter and write register stay in the top module.

Test Plan:
- Reset: RESET=1 for 3 cycles with FLAG_I=1 -> PM_WE=0, CPU_RESET=1, STATE=0, WORD_COUNT=0 throughout.
- Normal load: 4 words 0x20010005, 0x20020003, 0x00221820, 0xFFFFFFFF back-to-back, FLAG_STEP=0 -> writes at addr 0..3 one cycle after each sample; WORD_COUNT=4; CPU_RESET=0 and CPU_ENABLE=1 on the first RUN cycle. CPU_HALTED pulse -> CPU_ENABLE=0 next cycle, STATE=4.
- Step mode: same load with FLAG_STEP=1, three STEP pulses (one held high for 5 cycles) -> exactly 3 single-cycle CPU_ENABLE pulses, each one cycle after its edge.
- Overflow: ADDR_W=2, 6 non-halt words -> 4 writes (addr 0..3), words 5-6 dropped, OVERFLOW=1, WORD_COUNT=4, then RUN.
- FLAG_I drop: 2 words then FLAG_I=0 -> RUN after 2 writes. Later FLAG_I pulses in RUN produce no PM_WE.
- Reset mid-load: RESET after the 2nd of 4 words -> STATE=IDLE, WORD_COUNT=0. A fresh load then starts again at PM_ADDR=0.
